update_tick_scheduler: RTL and testbench

//  Sequences one game-update frame per must_update tick (1-cycle pulse in processor_clk domain).

---
 rtl/update_sched_pkg.sv | 34 +++
 rtl/update_tick_scheduler_watchdog.sv | 39 +++
 rtl/update_tick_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_update_tick_scheduler.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/update_sched_pkg.sv
// Shared types, state encodings and helpers for the update tick scheduler.
// Optional slot masking is controlled by UPDATE_SCHED_SLOT_MASK_EN.
package update_sched_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ISSUE  = 2'd1;
  localparam state_t ST_WAIT   = 2'd2;
  localparam state_t ST_FINISH = 2'd3;

  localparam int DEF_NUM_SLOTS = 4;
  localparam int DEF_TIMEOUT   = 1024;
  localparam int DEF_CNT_W     = 16;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_SLOT_W  = clog2_min1(DEF_NUM_SLOTS);
  localparam int DEF_TIMER_W = $clog2(DEF_TIMEOUT);

  // Increment that sticks at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input int          w
  );
    logic [31:0] top;
    top = (w >= 32) ? 32'hffff_ffff
                    : ((32'd1 << w) - 32'd1);
    return (v >= top) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/update_tick_scheduler_watchdog.sv
// Per-slot wait timer; one instance is shared by every slot because
// only one slot is ever awaited at a time.
module slot_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic cnt_en,
  output logic expired
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] LAST =
    TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] timer_q;
  logic [TIMER_W-1:0] timer_d;

  always_comb begin
    timer_d = timer_q;
    if (clear) begin
      timer_d = '0;
    end else if (cnt_en) begin
      timer_d = timer_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign expired = cnt_en && (timer_q == LAST);

endmodule

// File: rtl/update_tick_scheduler.sv
// Frame sequencer: one pass over all update slots per must_update tick.
// UPDATE_SCHED_SLOT_MASK_EN adds a per-frame slot_enable mask input.
module update_tick_scheduler
  import update_sched_pkg::*;
#(
  parameter int NUM_SLOTS      = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic                 processor_clk,
  input  logic                 reset,
  input  logic                 must_update,
  input  logic [NUM_SLOTS-1:0] slot_done,
`ifdef UPDATE_SCHED_SLOT_MASK_EN
  input  logic [NUM_SLOTS-1:0] slot_enable,
`endif
  input  logic                 clear_flags,
  output logic [NUM_SLOTS-1:0] slot_start,
  output logic [clog2_min1(NUM_SLOTS)-1:0]
                               active_slot,
  output logic                 busy,
  output logic                 frame_done,
  output logic [CNT_W-1:0]     frame_count,
  output logic [CNT_W-1:0]     overrun_count,
  output logic [NUM_SLOTS-1:0] timeout_flags
);

  localparam int SLOT_W = clog2_min1(NUM_SLOTS);

  state_t               state_q;
  state_t               state_d;
  logic [SLOT_W-1:0]    slot_q;
  logic [SLOT_W-1:0]    slot_d;
  logic                 pending_q;
  logic                 pending_d;
  logic [CNT_W-1:0]     frame_cnt_q;
  logic [CNT_W-1:0]     frame_cnt_d;
  logic [CNT_W-1:0]     ovr_q;
  logic [CNT_W-1:0]     ovr_d;
  logic [NUM_SLOTS-1:0] flags_q;
  logic [NUM_SLOTS-1:0] flags_d;

  logic [NUM_SLOTS-1:0] live_mask;
  logic [NUM_SLOTS-1:0] new_mask;
  logic                 start_frame;
  logic                 tick_busy;
  logic                 done_hit;
  logic                 wd_expired;
  logic                 first_hit;
  logic                 next_hit;
  logic [SLOT_W-1:0]    first_idx;
  logic [SLOT_W-1:0]    next_idx;

`ifdef UPDATE_SCHED_SLOT_MASK_EN
  logic [NUM_SLOTS-1:0] mask_q;
  logic [NUM_SLOTS-1:0] mask_d;

  // The mask is frozen for the whole frame at the tick that opens it.
  always_comb begin
    mask_d = mask_q;
    if (start_frame) begin
      mask_d = slot_enable;
    end
  end

  always_ff @(posedge processor_clk) begin
    if (!reset) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end

  assign new_mask  = slot_enable;
  assign live_mask = mask_q;
`else
  assign new_mask  = '1;
  assign live_mask = '1;
`endif

  // Lowest enabled slot for a new frame, and the
  // next enabled slot above the current one.
  always_comb begin
    first_hit = 1'b0;
    first_idx = '0;
    next_hit  = 1'b0;
    next_idx  = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (new_mask[i]) begin
        first_hit = 1'b1;
        first_idx = SLOT_W'(i);
      end
      if (live_mask[i] && (i > int'(slot_q))) begin
        next_hit = 1'b1;
        next_idx = SLOT_W'(i);
      end
    end
  end

  slot_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wd (
    .clk    (processor_clk),
    .reset  (reset),
    .clear  (state_q == ST_ISSUE),
    .cnt_en (state_q == ST_WAIT),
    .expired(wd_expired)
  );

  assign done_hit  = (state_q == ST_WAIT) &&
                     slot_done[slot_q];
  assign tick_busy = must_update &&
                     (state_q != ST_IDLE);

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    pending_d   = pending_q;
    frame_cnt_d = frame_cnt_q;
    ovr_d       = ovr_q;
    flags_d     = clear_flags ? '0 : flags_q;
    start_frame = 1'b0;

    if (tick_busy) begin
      ovr_d     = CNT_W'(sat_inc(32'(ovr_q), CNT_W));
      pending_d = 1'b1;
    end

    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (must_update) begin
          start_frame = 1'b1;
        end
      end
      (state_q == ST_ISSUE): begin
        state_d = ST_WAIT;
      end
      (state_q == ST_WAIT): begin
        if (done_hit || wd_expired) begin
          if (!done_hit) begin
            flags_d[slot_q] = 1'b1;
          end
          if (next_hit) begin
            state_d = ST_ISSUE;
            slot_d  = next_idx;
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      (state_q == ST_FINISH): begin
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
        // A tick landing in this very cycle also queues a frame.
        if (pending_q || must_update) begin
          start_frame = 1'b1;
          pending_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
          slot_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (start_frame) begin
      if (first_hit) begin
        state_d = ST_ISSUE;
        slot_d  = first_idx;
      end else begin
        state_d = ST_FINISH;
        slot_d  = '0;
      end
    end
  end

  always_ff @(posedge processor_clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      slot_q      <= '0;
      pending_q   <= 1'b0;
      frame_cnt_q <= '0;
      ovr_q       <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      pending_q   <= pending_d;
      frame_cnt_q <= frame_cnt_d;
      ovr_q       <= ovr_d;
      flags_q     <= flags_d;
    end
  end

  assign slot_start    = (state_q == ST_ISSUE)
                       ? (NUM_SLOTS'(1) << slot_q)
                       : '0;
  assign active_slot   = slot_q;
  assign busy          = (state_q != ST_IDLE);
  assign frame_done    = (state_q == ST_FINISH);
  assign frame_count   = frame_cnt_q;
  assign overrun_count = ovr_q;
  assign timeout_flags = flags_q;

endmodule

// File: tb/tb_update_tick_scheduler.sv
// Scoreboard bench for update_tick_scheduler (4 slots, 16-cycle watchdog).
// Build with UPDATE_SCHED_SLOT_MASK_EN to include the slot mask cases.
module tb_update_tick_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       must_update;
  logic       clear_flags;
  logic [3:0] slot_done;
  logic [3:0] slot_start;
  logic [1:0] active_slot;
  logic       busy;
  logic       frame_done;
  logic [15:0] frame_count;
  logic [15:0] overrun_count;
  logic [3:0] timeout_flags;
`ifdef UPDATE_SCHED_SLOT_MASK_EN
  logic [3:0] slot_enable;
`endif

  update_tick_scheduler #(
    .NUM_SLOTS     (4),
    .TIMEOUT_CYCLES(16),
    .CNT_W         (16)
  ) dut (
    .processor_clk(clk),
    .reset        (reset),
    .must_update  (must_update),
    .slot_done    (slot_done),
`ifdef UPDATE_SCHED_SLOT_MASK_EN
    .slot_enable  (slot_enable),
`endif
    .clear_flags  (clear_flags),
    .slot_start   (slot_start),
    .active_slot  (active_slot),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_count  (frame_count),
    .overrun_count(overrun_count),
    .timeout_flags(timeout_flags)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         fin;
    logic [3:0] val;
    int         at;
  } ev_t;

  ev_t        sb[$];
  int         errors = 0;
  int         checks = 0;
  int         delay[4];
  int         due[4];
  logic [3:0] stray = 4'b0;
  int         t;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic exp_start(int slot, int at);
    ev_t e;
    e.fin = 1'b0;
    e.val = 4'(1 << slot);
    e.at  = at;
    sb.push_back(e);
  endtask

  task automatic exp_fin(int at);
    ev_t e;
    e.fin = 1'b1;
    e.val = 4'b0;
    e.at  = at;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(int c);
    while (cyc < c) step();
  endtask

  task automatic pulse_tick();
    must_update = 1'b1;
    step();
    must_update = 1'b0;
  endtask

  task automatic set_delays(int a, int b, int c, int d);
    delay[0] = a;
    delay[1] = b;
    delay[2] = c;
    delay[3] = d;
  endtask

  task automatic drain(string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      step();
      n++;
    end
    chk({nm, "_drained"}, 32'(sb.size()), 32'd0);
    step();
    chk({nm, "_idle"}, 32'(busy), 32'd0);
  endtask

  // Monitor: every start pulse or frame end must match the queue head.
  initial forever begin
    ev_t e;
    @(negedge clk);
    if (slot_start != 4'b0 || frame_done) begin
      if (sb.size() == 0) begin
        chk("unexpected_output",
            {27'b0, frame_done, slot_start}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk(e.fin ? "frame_done_cycle" : "slot_start_cycle",
            32'(cyc), 32'(e.at));
        chk(e.fin ? "frame_done_kind" : "slot_start_kind",
            {27'b0, frame_done, slot_start},
            {27'b0, e.fin, e.val});
      end
    end
  end

  // Unit model: answer done delay[i] cycles after its start.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (slot_start[i] && delay[i] > 0) due[i] = cyc + delay[i];
    end
  end

  initial begin
    slot_done = 4'b0;
    forever begin
      @(posedge clk);
      #2;
      slot_done = stray;
      for (int i = 0; i < 4; i++) begin
        if (due[i] == cyc) begin
          slot_done[i] = 1'b1;
          due[i] = -1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int i = 0; i < 4; i++) due[i] = -1;
    set_delays(3, 3, 3, 3);
    reset       = 1'b0;
    must_update = 1'b1;
    clear_flags = 1'b0;
`ifdef UPDATE_SCHED_SLOT_MASK_EN
    slot_enable = 4'b1111;
`endif
    repeat (3) step();
    chk("rst_slot_start", 32'(slot_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_overrun", 32'(overrun_count), 32'd0);
    chk("rst_flags", 32'(timeout_flags), 32'd0);
    chk("rst_active", 32'(active_slot), 32'd0);
    reset       = 1'b1;
    must_update = 1'b0;
    step();

    // Normal frame: starts at +1,+5,+9,+13, frame end at +17.
    t = cyc;
    exp_start(0, t + 1);
    exp_start(1, t + 5);
    exp_start(2, t + 9);
    exp_start(3, t + 13);
    exp_fin(t + 17);
    pulse_tick();
    wait_to(t + 6);
    chk("mid_active", 32'(active_slot), 32'd1);
    chk("mid_busy", 32'(busy), 32'd1);
    drain("normal");
    chk("normal_frames", 32'(frame_count), 32'd1);
    chk("normal_flags", 32'(timeout_flags), 32'd0);

    // Slot 2 silent: next start 17 cycles later, flag set.
    set_delays(3, 3, 0, 3);
    t = cyc;
    exp_start(0, t + 1);
    exp_start(1, t + 5);
    exp_start(2, t + 9);
    exp_start(3, t + 26);
    exp_fin(t + 30);
    pulse_tick();
    wait_to(t + 25);
    chk("to_flag_before", 32'(timeout_flags), 32'd0);
    wait_to(t + 26);
    chk("to_flag_after", 32'(timeout_flags), 32'h4);
    drain("timeout");
    chk("timeout_frames", 32'(frame_count), 32'd2);
    chk("timeout_flags", 32'(timeout_flags), 32'h4);
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    chk("cleared_flags", 32'(timeout_flags), 32'd0);

    // Two extra ticks mid-frame queue exactly one more frame.
    set_delays(3, 3, 3, 3);
    t = cyc;
    exp_start(0, t + 1);
    exp_start(1, t + 5);
    exp_start(2, t + 9);
    exp_start(3, t + 13);
    exp_fin(t + 17);
    exp_start(0, t + 18);
    exp_start(1, t + 22);
    exp_start(2, t + 26);
    exp_start(3, t + 30);
    exp_fin(t + 34);
    pulse_tick();
    wait_to(t + 3);
    pulse_tick();
    wait_to(t + 8);
    pulse_tick();
    drain("overrun");
    chk("overrun_count", 32'(overrun_count), 32'd2);
    chk("overrun_frames", 32'(frame_count), 32'd4);

    // Done on the last watchdog cycle; stray dones ignored.
    set_delays(3, 16, 3, 3);
    t = cyc;
    exp_start(0, t + 1);
    exp_start(1, t + 5);
    exp_start(2, t + 22);
    exp_start(3, t + 26);
    exp_fin(t + 30);
    pulse_tick();
    wait_to(t + 7);
    stray = 4'b1000;
    step();
    stray = 4'b0000;
    wait_to(t + 22);
    stray = 4'b0100;
    step();
    stray = 4'b0000;
    drain("collide");
    chk("collide_flags", 32'(timeout_flags), 32'd0);
    chk("collide_frames", 32'(frame_count), 32'd5);
    chk("collide_overrun", 32'(overrun_count), 32'd2);

`ifdef UPDATE_SCHED_SLOT_MASK_EN
    set_delays(3, 3, 3, 3);
    slot_enable = 4'b1010;
    t = cyc;
    exp_start(1, t + 1);
    exp_start(3, t + 5);
    exp_fin(t + 9);
    pulse_tick();
    slot_enable = 4'b1111;
    drain("mask_1010");
    chk("mask_frames", 32'(frame_count), 32'd6);

    slot_enable = 4'b0000;
    t = cyc;
    exp_fin(t + 1);
    pulse_tick();
    drain("mask_none");
    chk("mask_none_frames", 32'(frame_count), 32'd7);
`endif

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
